// File: rtl/spi_burst_pkg.sv
// Shared types and widths for the SPI burst sequencer and its FIFOs.
package spi_burst_pkg;

    localparam int SPI_DW = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        HOLD  = 3'd4
    } state_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with a directly visible head; push is dropped when full, pop when empty.
module spi_sync_fifo #(
    parameter int  DW    = 8,
    parameter int  DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [DW-1:0] din_i,
    input  logic          pop_i,
    output logic [DW-1:0] dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

endmodule

// File: rtl/spi_burst_ctrl.sv
// Burst sequencer in front of an SPI master: admits N-byte bursts, frames them with
// slave select and collects the received bytes into an RX FIFO.
module spi_burst_ctrl
    import spi_burst_pkg::*;
#(
    parameter int  DEPTH    = 16,
    parameter int  SS_SETUP = 2,
    parameter int  SS_HOLD  = 2,
    localparam int LW       = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [SPI_DW-1:0] tx_data_i,
    input  logic              tx_valid_i,
    output logic              tx_ready_o,
    input  logic              go_i,
    input  logic [LW-1:0]     len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [SPI_DW-1:0] rx_data_o,
    output logic              rx_valid_o,
    input  logic              rx_ready_i,
    output logic              ss_n_o,
    output logic [SPI_DW-1:0] spi_din_o,
    output logic              spi_start_o,
    input  logic              spi_ready_i,
    input  logic              spi_done_tick_i,
    input  logic [SPI_DW-1:0] spi_dout_i
);

    localparam int CMAX = (SS_SETUP > SS_HOLD) ? SS_SETUP : SS_HOLD;
    localparam int CW   = $clog2(CMAX + 1);

    state_t            state_q, state_d;
    logic [LW-1:0]     rem_q, rem_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ss_n_q, ss_n_d;
    logic              start_q, start_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic [SPI_DW-1:0] din_q, din_d;

    logic              tx_pop, tx_full, tx_empty;
    logic              rx_push, rx_full, rx_empty;
    logic [SPI_DW-1:0] tx_head;
    logic [LW-1:0]     tx_count, rx_count, rx_free;
    logic              admit;

    spi_sync_fifo #(.DW(SPI_DW), .DEPTH(DEPTH)) u_tx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (reset_i),
        .push_i  (tx_valid_i),
        .din_i   (tx_data_i),
        .pop_i   (tx_pop),
        .dout_o  (tx_head),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count)
    );

    spi_sync_fifo #(.DW(SPI_DW), .DEPTH(DEPTH)) u_rx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (reset_i),
        .push_i  (rx_push),
        .din_i   (spi_dout_i),
        .pop_i   (rx_ready_i),
        .dout_o  (rx_data_o),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count)
    );

    assign tx_ready_o = ~tx_full;
    assign rx_valid_o = ~rx_empty;
    assign rx_free    = rx_full ? '0 : LW'(DEPTH) - rx_count;
    assign admit      = (len_i != '0) && !tx_empty && (tx_count >= len_i) && (rx_free >= len_i);

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        ss_n_d  = ss_n_q;
        din_d   = din_q;
        start_d = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        tx_pop  = 1'b0;
        rx_push = 1'b0;
        case (state_q)
            IDLE: begin
                if (go_i) begin
                    if (admit) begin
                        rem_d  = len_i;
                        ss_n_d = 1'b0;
                        // The start is registered out of ISSUE, so setup counts one cycle fewer.
                        if (SS_SETUP == 1) begin
                            state_d = ISSUE;
                        end else begin
                            state_d = SETUP;
                            cnt_d   = CW'(SS_SETUP - 2);
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SETUP: begin
                if (cnt_q == '0) state_d = ISSUE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ISSUE: begin
                if (spi_ready_i) begin
                    start_d = 1'b1;
                    din_d   = tx_head;
                    tx_pop  = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (spi_done_tick_i) begin
                    rx_push = 1'b1;
                    rem_d   = rem_q - 1'b1;
                    if (rem_q == LW'(1)) begin
                        cnt_d   = CW'(SS_HOLD - 1);
                        state_d = HOLD;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    ss_n_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            rem_q   <= '0;
            cnt_q   <= '0;
            ss_n_q  <= 1'b1;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            ss_n_q  <= ss_n_d;
            start_q <= start_d;
            done_q  <= done_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            din_q   <= din_d;
        end
    end

    assign ss_n_o      = ss_n_q;
    assign spi_start_o = start_q;
    assign spi_din_o   = din_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Bench for spi_burst_ctrl: directed scenarios plus random traffic, checked every cycle
// against a timestamp-based behavioural model of bursts and FIFO contents.
module tb_spi_burst_ctrl;

    localparam int DEPTH    = 8;
    localparam int SS_SETUP = 3;
    localparam int SS_HOLD  = 4;
    localparam int LW       = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset_n = 1'b1;
    logic [7:0]    tx_data_i = '0;
    logic          tx_valid_i = 1'b0;
    logic          tx_ready_o;
    logic          go_i = 1'b0;
    logic [LW-1:0] len_i = '0;
    logic          busy_o, done_o, err_o;
    logic [7:0]    rx_data_o;
    logic          rx_valid_o;
    logic          rx_ready_i = 1'b0;
    logic          ss_n_o;
    logic [7:0]    spi_din_o;
    logic          spi_start_o;
    logic          spi_ready_i = 1'b0;
    logic          spi_done_tick_i = 1'b0;
    logic [7:0]    spi_dout_i = '0;

    spi_burst_ctrl #(.DEPTH(DEPTH), .SS_SETUP(SS_SETUP), .SS_HOLD(SS_HOLD)) dut (
        .clk_i           (clk),
        .reset_i         (reset_n),
        .tx_data_i       (tx_data_i),
        .tx_valid_i      (tx_valid_i),
        .tx_ready_o      (tx_ready_o),
        .go_i            (go_i),
        .len_i           (len_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .err_o           (err_o),
        .rx_data_o       (rx_data_o),
        .rx_valid_o      (rx_valid_o),
        .rx_ready_i      (rx_ready_i),
        .ss_n_o          (ss_n_o),
        .spi_din_o       (spi_din_o),
        .spi_start_o     (spi_start_o),
        .spi_ready_i     (spi_ready_i),
        .spi_done_tick_i (spi_done_tick_i),
        .spi_dout_i      (spi_dout_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Behavioural model: bursts tracked as edge timestamps, FIFOs as queues.
    byte unsigned m_txq[$];
    byte unsigned m_rxq[$];
    int           m_cyc = 0, m_issue_at = 0, m_hold_at = -1, m_rem = 0;
    bit           m_busy = 0, m_wait = 0, m_ss_n = 1, m_start = 0, m_done = 0, m_err = 0;
    logic [7:0]   m_din = '0;

    always @(posedge clk or negedge reset_n) begin
        int txn, rxn;
        if (!reset_n) begin
            m_txq.delete(); m_rxq.delete();
            m_busy = 0; m_wait = 0; m_ss_n = 1; m_start = 0; m_done = 0; m_err = 0;
            m_din = '0; m_hold_at = -1; m_rem = 0;
        end else begin
            m_cyc++;
            txn = m_txq.size();
            rxn = m_rxq.size();
            m_start = 0; m_done = 0; m_err = 0;
            if (rx_ready_i && rxn > 0) void'(m_rxq.pop_front());
            if (!m_busy) begin
                if (go_i) begin
                    if (len_i == 0 || txn < int'(len_i) || (DEPTH - rxn) < int'(len_i)) begin
                        m_err = 1;
                    end else begin
                        m_busy = 1; m_ss_n = 0; m_rem = int'(len_i);
                        m_issue_at = m_cyc + SS_SETUP; m_wait = 0; m_hold_at = -1;
                    end
                end
            end else if (m_hold_at >= 0) begin
                if (m_cyc == m_hold_at) begin
                    m_ss_n = 1; m_done = 1; m_busy = 0;
                end
            end else if (!m_wait) begin
                if (m_cyc >= m_issue_at && spi_ready_i) begin
                    m_start = 1; m_din = m_txq.pop_front(); m_wait = 1;
                end
            end else if (spi_done_tick_i) begin
                m_rxq.push_back(spi_dout_i);
                m_rem--; m_wait = 0;
                if (m_rem == 0) m_hold_at = m_cyc + SS_HOLD;
                else            m_issue_at = m_cyc + 1;
            end
            if (tx_valid_i && txn < DEPTH) m_txq.push_back(tx_data_i);
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            chk("ss_n", int'(ss_n_o), int'(m_ss_n));
            chk("start", int'(spi_start_o), int'(m_start));
            chk("din", int'(spi_din_o), int'(m_din));
            chk("done", int'(done_o), int'(m_done));
            chk("err", int'(err_o), int'(m_err));
            chk("busy", int'(busy_o), int'(m_busy));
            chk("tx_ready", int'(tx_ready_o), int'(m_txq.size() < DEPTH));
            chk("rx_valid", int'(rx_valid_o), int'(m_rxq.size() != 0));
            if (m_rxq.size() != 0) chk("rx_data", int'(rx_data_o), int'(m_rxq[0]));
        end
    end

    // Event monitor for directed measurements.
    int           start_cnt = 0, done_cnt = 0, err_cnt = 0;
    int           fall_cyc = 0, first_start_cyc = 0, rise_cyc = 0, tick_edge = 0;
    bit           want_first = 0;
    logic         prev_ss_n = 1'b1;
    byte unsigned start_log[$];

    always @(negedge clk) begin
        if (reset_n) begin
            if (prev_ss_n && !ss_n_o) begin fall_cyc = cyc; want_first = 1; end
            if (!prev_ss_n && ss_n_o) rise_cyc = cyc;
            if (spi_start_o) begin
                start_cnt++;
                start_log.push_back(spi_din_o);
                if (want_first) begin first_start_cyc = cyc; want_first = 0; end
            end
            if (done_o) begin done_cnt++; $display("burst done at cycle %0d", cyc); end
            if (err_o) begin err_cnt++; $display("request rejected at cycle %0d", cyc); end
        end
        prev_ss_n = ss_n_o;
    end

    // SPI master stand-in: answers each start with a done tick 1..4 cycles later.
    int           pending = 0;
    byte unsigned resp_q[$];

    always @(negedge clk) begin
        if (!reset_n) begin
            pending = 0;
            spi_done_tick_i = 1'b0;
        end else begin
            spi_done_tick_i = 1'b0;
            if (pending > 0) begin
                pending--;
                if (pending == 0) begin
                    spi_done_tick_i = 1'b1;
                    if (resp_q.size() > 0) spi_dout_i = resp_q.pop_front();
                    else                   spi_dout_i = 8'($urandom);
                    if (!ss_n_o) tick_edge = cyc + 1;
                end
            end else if (ss_n_o && $urandom_range(0, 7) == 0) begin
                spi_done_tick_i = 1'b1;
                spi_dout_i = 8'($urandom);
            end
            if (spi_start_o) pending = $urandom_range(1, 4);
        end
    end

    task automatic push_tx(input int b);
        tx_data_i = 8'(b); tx_valid_i = 1'b1;
        @(negedge clk);
        tx_valid_i = 1'b0;
    endtask

    task automatic do_go(input int n);
        len_i = LW'(n); go_i = 1'b1;
        @(negedge clk);
        go_i = 1'b0;
    endtask

    task automatic pop_rx(input int req, input string name);
        chk({name, "_valid"}, int'(rx_valid_o), 1);
        chk(name, int'(rx_data_o), req);
        rx_ready_i = 1'b1;
        @(negedge clk);
        rx_ready_i = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        @(negedge clk);
        while (busy_o && n < budget) begin @(negedge clk); n++; end
        chk("idle_timeout", int'(busy_o), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, d0, n;
        #1 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ss_n", int'(ss_n_o), 1);
        chk("rst_start", int'(spi_start_o), 0);
        chk("rst_din", int'(spi_din_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_err", int'(err_o), 0);
        chk("rst_tx_ready", int'(tx_ready_o), 1);
        chk("rst_rx_valid", int'(rx_valid_o), 0);
        reset_n = 1'b1;
        @(negedge clk);
        spi_ready_i = 1'b1;

        // Basic two-byte burst with fixed master replies.
        resp_q.push_back(8'h11); resp_q.push_back(8'h22);
        push_tx('hA5); push_tx('h3C);
        s0 = start_log.size(); d0 = done_cnt;
        do_go(2);
        chk("basic_busy", int'(busy_o), 1);
        chk("basic_ss_low", int'(ss_n_o), 0);
        wait_idle(200);
        @(negedge clk);
        chk("basic_starts", start_log.size() - s0, 2);
        chk("basic_din0", int'(start_log[s0]), 'hA5);
        chk("basic_din1", int'(start_log[s0 + 1]), 'h3C);
        chk("basic_done", done_cnt - d0, 1);
        chk("setup_cycles", first_start_cyc - fall_cyc, SS_SETUP);
        chk("hold_cycles", rise_cyc - tick_edge, SS_HOLD);
        pop_rx('h11, "basic_rx0");
        pop_rx('h22, "basic_rx1");

        // Rejected requests.
        do_go(0);
        chk("err_len0", int'(err_o), 1);
        push_tx('h5A);
        do_go(2);
        chk("err_short_tx", int'(err_o), 1);
        chk("err_ss_n", int'(ss_n_o), 1);
        chk("err_busy", int'(busy_o), 0);
        @(negedge clk);
        chk("err_one_cycle", int'(err_o), 0);

        // Fill TX to DEPTH, then a blocked push.
        n = 0;
        while (tx_ready_o && n < 2 * DEPTH) begin push_tx(int'($urandom_range(0, 255))); n++; end
        chk("fill_pushes", n, DEPTH - 1);
        chk("fill_tx_ready", int'(tx_ready_o), 0);
        push_tx('hEE);

        // Full-depth burst with slow ready and an ignored go.
        spi_ready_i = 1'b0;
        s0 = start_cnt;
        do_go(DEPTH);
        repeat (SS_SETUP + 10) @(negedge clk);
        chk("slow_no_start", start_cnt - s0, 0);
        do_go(1);
        chk("busy_go_no_err", int'(err_o), 0);
        chk("busy_go_busy", int'(busy_o), 1);
        spi_ready_i = 1'b1;
        @(negedge clk);
        chk("slow_start_after_ready", int'(spi_start_o), 1);
        wait_idle(500);
        chk("full_burst_starts", start_cnt - s0, DEPTH);
        chk("drained_tx_ready", int'(tx_ready_o), 1);
        chk("rx_full_valid", int'(rx_valid_o), 1);
        push_tx('h61);
        do_go(1);
        chk("err_rx_full", int'(err_o), 1);
        rx_ready_i = 1'b1;
        repeat (DEPTH) @(negedge clk);
        rx_ready_i = 1'b0;
        chk("rx_drained", int'(rx_valid_o), 0);

        // Reset in the middle of a burst.
        do_go(1);
        wait_idle(200);
        push_tx('h77); push_tx('h88);
        do_go(1);
        n = 0;
        while (!spi_start_o && n < 50) begin @(negedge clk); n++; end
        chk("rst_saw_start", int'(spi_start_o), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_ss_n", int'(ss_n_o), 1);
        chk("midrst_rx_valid", int'(rx_valid_o), 0);
        chk("midrst_tx_ready", int'(tx_ready_o), 1);
        chk("midrst_busy", int'(busy_o), 0);
        chk("midrst_done", int'(done_o), 0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        do_go(1);
        chk("midrst_tx_flushed", int'(err_o), 1);
        resp_q.push_back(8'h99);
        push_tx('h42);
        d0 = done_cnt;
        do_go(1);
        wait_idle(200);
        @(negedge clk);
        chk("post_rst_done", done_cnt - d0, 1);
        pop_rx('h99, "post_rst_rx");

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            tx_valid_i  = ($urandom_range(0, 2) == 0);
            tx_data_i   = 8'($urandom);
            rx_ready_i  = ($urandom_range(0, 1) == 0);
            go_i        = ($urandom_range(0, 7) == 0);
            len_i       = LW'($urandom_range(0, DEPTH));
            spi_ready_i = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end
        tx_valid_i = 1'b0; rx_ready_i = 1'b0; go_i = 1'b0; spi_ready_i = 1'b1;
        wait_idle(500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
